// File: rtl/sha512_block_sequencer_if.sv
// sha512_block_sequencer_if: bundles the three handshakes around the SHA-512
// block sequencer: message intake (valid/ready), compression core
// (start/done) and digest output (valid/ready), plus the timeout error pulse.
// The slave modport is the sequencer's view; the master modport is the
// surrounding environment (message producer, compression core and digest
// consumer).
interface sha512_block_sequencer_if;
  logic          msg_valid;
  logic          msg_ready;
  logic [1023:0] msg_data;
  logic [1:0]    msg_mode;

  logic          blk_start;
  logic [1023:0] blk_data;
  logic          blk_first;
  logic          core_done;
  logic [511:0]  core_hash;

  logic          dig_valid;
  logic          dig_ready;
  logic [511:0]  dig_data;

  logic          err_timeout;

  modport slave (
    input  msg_valid, msg_data, msg_mode, core_done, core_hash, dig_ready,
    output msg_ready, blk_start, blk_data, blk_first, dig_valid, dig_data,
           err_timeout
  );

  modport master (
    output msg_valid, msg_data, msg_mode, core_done, core_hash, dig_ready,
    input  msg_ready, blk_start, blk_data, blk_first, dig_valid, dig_data,
           err_timeout
  );
endinterface

// File: rtl/sha512_block_sequencer.sv
// sha512_block_sequencer: front-end controller for the SHA-512 hash path of
// the Ed25519 datapath. Accepts one 32/96/128-byte message, pads it into one
// or two 1024-bit blocks, drives them through the compression core with a
// start/done handshake and holds the resulting digest until it is consumed.
// A per-block watchdog drops the transaction if the core never answers.
// Optional feature: define SHA512_SEQ_PERF_EN to add the perf_cycles
// latency counter output.
module sha512_block_sequencer #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic clk,
  input  logic rst_n,
  sha512_block_sequencer_if.slave bus
`ifdef SHA512_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    B1_GO,
    B1_WAIT,
    B2_GO,
    B2_WAIT,
    OUT
  } state_t;

  // Second block of a 128-byte message carries only padding and the length.
  localparam logic [1023:0] BLOCK2 = {8'h80, 888'b0, 64'd0, 64'd1024};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_t           state;
  state_t           next_state;
  logic [1:0]       mode;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             load_b2;
  logic             latch_dig;
  logic             expired;
  logic             two_blk;

  // First block: message followed by 0x80, zero fill and the 128-bit bit length.
  function automatic logic [1023:0] pad_block1(input logic [1023:0] m,
                                               input logic [1:0]    md);
    logic [1023:0] b;
    case (md)
      2'd0:    b = {m[255:0], 8'h80, 632'b0, 64'd0, 64'd256};
      2'd1:    b = {m[767:0], 8'h80, 120'b0, 64'd0, 64'd768};
      default: b = m;
    endcase
    return b;
  endfunction

  assign two_blk = (mode == 2'd2) || (mode == 2'd3);
  assign expired = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT);

  // State register; reset abandons any in-flight message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs; core_done only matters in WAIT states and beats the timeout.
  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    load_b2         = 1'b0;
    latch_dig       = 1'b0;
    bus.msg_ready   = 1'b0;
    bus.blk_start   = 1'b0;
    bus.dig_valid   = 1'b0;
    bus.err_timeout = 1'b0;
    case (state)
      IDLE: begin
        bus.msg_ready = 1'b1;
        if (bus.msg_valid) begin
          accept     = 1'b1;
          next_state = B1_GO;
        end
      end
      B1_GO: begin
        bus.blk_start = 1'b1;
        next_state    = B1_WAIT;
      end
      B1_WAIT: begin
        if (bus.core_done) begin
          if (two_blk) begin
            load_b2    = 1'b1;
            next_state = B2_GO;
          end else begin
            latch_dig  = 1'b1;
            next_state = OUT;
          end
        end else if (expired) begin
          bus.err_timeout = 1'b1;
          next_state      = IDLE;
        end
      end
      B2_GO: begin
        bus.blk_start = 1'b1;
        next_state    = B2_WAIT;
      end
      B2_WAIT: begin
        if (bus.core_done) begin
          latch_dig  = 1'b1;
          next_state = OUT;
        end else if (expired) begin
          bus.err_timeout = 1'b1;
          next_state      = IDLE;
        end
      end
      OUT: begin
        bus.dig_valid = 1'b1;
        if (bus.dig_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Watchdog counter: cleared while a block is being started, counts each WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == B1_GO || state == B2_GO) begin
      wait_cnt <= '0;
    end else if ((state == B1_WAIT || state == B2_WAIT) && !expired) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Block, block-type, mode and digest registers; blk_data doubles as the message store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.blk_data  <= '0;
      bus.blk_first <= 1'b0;
      bus.dig_data  <= '0;
      mode          <= '0;
    end else begin
      if (accept) begin
        bus.blk_data  <= pad_block1(bus.msg_data, bus.msg_mode);
        bus.blk_first <= 1'b1;
        mode          <= bus.msg_mode;
      end else if (load_b2) begin
        bus.blk_data  <= BLOCK2;
        bus.blk_first <= 1'b0;
      end
      if (latch_dig) bus.dig_data <= bus.core_hash;
    end
  end

`ifdef SHA512_SEQ_PERF_EN
  logic perf_run;

  // Latency counter: restarts on accept, runs until the digest appears, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_run    <= 1'b0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_run    <= 1'b1;
    end else if (perf_run) begin
      if (state == OUT || state == IDLE) begin
        perf_run <= 1'b0;
      end else if (perf_cycles != 32'hFFFF_FFFF) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sha512_block_sequencer.sv
// tb_sha512_block_sequencer: directed bench for the SHA-512 block sequencer.
// The DUT runs with TIMEOUT = 8 so the watchdog can be exercised quickly.
// Inputs are driven 1 ns after the rising edge and outputs are checked there
// or on the falling edge; expected blocks and digests are built in the bench.
`timescale 1ns/1ps
module tb_sha512_block_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   start_pulses = 0;
  int   err_pulses = 0;

  sha512_block_sequencer_if bus();

`ifdef SHA512_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  sha512_block_sequencer #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SHA512_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  localparam logic [1023:0] BLOCK2 = {8'h80, 888'b0, 64'd0, 64'd1024};

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count start and timeout pulses on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (bus.blk_start === 1'b1) start_pulses++;
    if (bus.err_timeout === 1'b1) err_pulses++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one message for a single cycle.
  task automatic send_msg(input logic [1023:0] d, input logic [1:0] md);
    bus.msg_valid = 1'b1;
    bus.msg_data  = d;
    bus.msg_mode  = md;
    cyc();
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    bus.msg_mode  = 2'd0;
  endtask

  // Reset values while held in reset and msg_ready after release.
  task automatic test_reset();
    rst_n          = 1'b0;
    bus.msg_valid  = 1'b0;
    bus.msg_data   = '0;
    bus.msg_mode   = 2'd0;
    bus.core_done  = 1'b0;
    bus.core_hash  = '0;
    bus.dig_ready  = 1'b0;
    repeat (3) cyc();
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_msg_ready: got %b expected 1", bus.msg_ready); end
    checks++; if (bus.blk_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_blk_start: got %b expected 0", bus.blk_start); end
    checks++; if (bus.blk_first !== 1'b0) begin errors++; $display("[TB] FAIL reset_blk_first: got %b expected 0", bus.blk_first); end
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dig_valid: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_timeout: got %b expected 0", bus.err_timeout); end
    checks++; if (bus.blk_data !== 1024'd0) begin errors++; $display("[TB] FAIL reset_blk_data: got %h expected 0", bus.blk_data[1023:512]); end
    checks++; if (bus.dig_data !== 512'd0) begin errors++; $display("[TB] FAIL reset_dig_data: got %h expected 0", bus.dig_data); end
    rst_n = 1'b1;
    cyc();
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_msg_ready: got %b expected 1", bus.msg_ready); end
  endtask

  // Mode 0: single padded block, digest from the first core_done.
  task automatic test_mode0();
    logic [255:0]  m;
    logic [1023:0] exp;
    logic [511:0]  h;
    int            p0;
    m = '0;
    for (int i = 0; i < 32; i++) m[255 - 8*i -: 8] = 8'(i + 1);
    exp = {m, 8'h80, 632'b0, 64'd0, 64'd256};
    h   = {16{32'hC0DE_0001}};
    p0  = start_pulses;
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL m0_msg_ready: got %b expected 1", bus.msg_ready); end
    send_msg({{768{1'b1}}, m}, 2'd0);
    checks++; if (bus.blk_start !== 1'b1) begin errors++; $display("[TB] FAIL m0_blk_start: got %b expected 1", bus.blk_start); end
    checks++; if (bus.blk_first !== 1'b1) begin errors++; $display("[TB] FAIL m0_blk_first: got %b expected 1", bus.blk_first); end
    checks++; if (bus.blk_data[1023:512] !== exp[1023:512]) begin errors++; $display("[TB] FAIL m0_blk_hi: got %h expected %h", bus.blk_data[1023:512], exp[1023:512]); end
    checks++; if (bus.blk_data[511:0] !== exp[511:0]) begin errors++; $display("[TB] FAIL m0_blk_lo: got %h expected %h", bus.blk_data[511:0], exp[511:0]); end
    checks++; if (bus.msg_ready !== 1'b0) begin errors++; $display("[TB] FAIL m0_busy_ready: got %b expected 0", bus.msg_ready); end
    cyc();
    checks++; if (bus.blk_start !== 1'b0) begin errors++; $display("[TB] FAIL m0_start_pulse: got %b expected 0", bus.blk_start); end
    checks++; if (bus.blk_data[1023:512] !== exp[1023:512]) begin errors++; $display("[TB] FAIL m0_blk_hold: got %h expected %h", bus.blk_data[1023:512], exp[1023:512]); end
    bus.core_done = 1'b1;
    bus.core_hash = h;
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    checks++; if (bus.dig_valid !== 1'b1) begin errors++; $display("[TB] FAIL m0_dig_valid: got %b expected 1", bus.dig_valid); end
    checks++; if (bus.dig_data !== h) begin errors++; $display("[TB] FAIL m0_dig_data: got %h expected %h", bus.dig_data, h); end
    bus.dig_ready = 1'b1;
    cyc();
    bus.dig_ready = 1'b0;
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL m0_dig_release: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL m0_idle_ready: got %b expected 1", bus.msg_ready); end
    checks++; if (start_pulses - p0 !== 1) begin errors++; $display("[TB] FAIL m0_start_count: got %0d expected 1", start_pulses - p0); end
  endtask

  // Mode 2: message block then padding block; core_done during blk_start is ignored.
  task automatic test_mode2();
    logic [1023:0] m;
    logic [511:0]  ha;
    logic [511:0]  hx;
    logic [511:0]  hb;
    int            p0;
    m  = {128{8'hAA}};
    ha = {16{32'h1111_2222}};
    hx = {16{32'h3333_4444}};
    hb = {16{32'h5555_6666}};
    p0 = start_pulses;
    send_msg(m, 2'd2);
    checks++; if (bus.blk_start !== 1'b1) begin errors++; $display("[TB] FAIL m2_start1: got %b expected 1", bus.blk_start); end
    checks++; if (bus.blk_first !== 1'b1) begin errors++; $display("[TB] FAIL m2_first1: got %b expected 1", bus.blk_first); end
    checks++; if (bus.blk_data !== m) begin errors++; $display("[TB] FAIL m2_blk1: got %h expected %h", bus.blk_data[1023:512], m[1023:512]); end
    cyc();
    bus.core_done = 1'b1;
    bus.core_hash = ha;
    cyc();
    bus.core_hash = hx;
    checks++; if (bus.blk_start !== 1'b1) begin errors++; $display("[TB] FAIL m2_start2: got %b expected 1", bus.blk_start); end
    checks++; if (bus.blk_first !== 1'b0) begin errors++; $display("[TB] FAIL m2_first2: got %b expected 0", bus.blk_first); end
    checks++; if (bus.blk_data[1023:512] !== BLOCK2[1023:512]) begin errors++; $display("[TB] FAIL m2_blk2_hi: got %h expected %h", bus.blk_data[1023:512], BLOCK2[1023:512]); end
    checks++; if (bus.blk_data[511:0] !== BLOCK2[511:0]) begin errors++; $display("[TB] FAIL m2_blk2_lo: got %h expected %h", bus.blk_data[511:0], BLOCK2[511:0]); end
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL m2_early_dig: got %b expected 0", bus.dig_valid); end
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL m2_done_in_go_ignored: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.blk_data[63:0] !== 64'd1024) begin errors++; $display("[TB] FAIL m2_blk2_hold: got %h expected %h", bus.blk_data[63:0], 64'd1024); end
    cyc();
    bus.core_done = 1'b1;
    bus.core_hash = hb;
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    checks++; if (bus.dig_valid !== 1'b1) begin errors++; $display("[TB] FAIL m2_dig_valid: got %b expected 1", bus.dig_valid); end
    checks++; if (bus.dig_data !== hb) begin errors++; $display("[TB] FAIL m2_dig_data: got %h expected %h", bus.dig_data, hb); end
    bus.dig_ready = 1'b1;
    cyc();
    bus.dig_ready = 1'b0;
    checks++; if (start_pulses - p0 !== 2) begin errors++; $display("[TB] FAIL m2_start_count: got %0d expected 2", start_pulses - p0); end
  endtask

  // Mode 1 with the digest consumer stalling for 20 cycles.
  task automatic test_mode1_backpressure();
    logic [767:0]  m;
    logic [1023:0] exp;
    logic [511:0]  h;
    m   = {24{32'h1357_9BDF}};
    exp = {m, 8'h80, 120'b0, 64'd0, 64'd768};
    h   = {16{32'h89AB_CDEF}};
    send_msg({{256{1'b1}}, m}, 2'd1);
    checks++; if (bus.blk_data[1023:512] !== exp[1023:512]) begin errors++; $display("[TB] FAIL m1_blk_hi: got %h expected %h", bus.blk_data[1023:512], exp[1023:512]); end
    checks++; if (bus.blk_data[511:0] !== exp[511:0]) begin errors++; $display("[TB] FAIL m1_blk_lo: got %h expected %h", bus.blk_data[511:0], exp[511:0]); end
    cyc();
    bus.core_done = 1'b1;
    bus.core_hash = h;
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.dig_valid !== 1'b1) begin errors++; $display("[TB] FAIL m1_hold_valid[%0d]: got %b expected 1", i, bus.dig_valid); end
      checks++; if (bus.dig_data !== h) begin errors++; $display("[TB] FAIL m1_hold_data[%0d]: got %h expected %h", i, bus.dig_data, h); end
      checks++; if (bus.msg_ready !== 1'b0) begin errors++; $display("[TB] FAIL m1_hold_ready[%0d]: got %b expected 0", i, bus.msg_ready); end
      cyc();
    end
    bus.dig_ready = 1'b1;
    cyc();
    bus.dig_ready = 1'b0;
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL m1_release_valid: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL m1_release_ready: got %b expected 1", bus.msg_ready); end
  endtask

  // Core never answers: err_timeout 8 cycles after WAIT entry, then a normal message.
  task automatic test_timeout();
    logic [511:0] h;
    int           e0;
    h  = {16{32'hFEED_0008}};
    e0 = err_pulses;
    send_msg({4{256'h0123_4567_89AB_CDEF}}, 2'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_early_err[%0d]: got %b expected 0", k, bus.err_timeout); end
    end
    cyc();
    checks++; if (bus.err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_err_pulse: got %b expected 1", bus.err_timeout); end
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_dig_valid: got %b expected 0", bus.dig_valid); end
    cyc();
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_err_one_cycle: got %b expected 0", bus.err_timeout); end
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_idle_ready: got %b expected 1", bus.msg_ready); end
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_no_digest: got %b expected 0", bus.dig_valid); end
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("[TB] FAIL to_err_count: got %0d expected 1", err_pulses - e0); end
    send_msg({4{256'h0123_4567_89AB_CDEF}}, 2'd0);
    cyc();
    bus.core_done = 1'b1;
    bus.core_hash = h;
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    checks++; if (bus.dig_data !== h) begin errors++; $display("[TB] FAIL to_next_msg_digest: got %h expected %h", bus.dig_data, h); end
    bus.dig_ready = 1'b1;
    cyc();
    bus.dig_ready = 1'b0;
  endtask

  // core_done arriving in the timeout cycle wins over the error.
  task automatic test_timeout_race();
    logic [511:0] h;
    int           e0;
    h  = {16{32'hACED_0009}};
    e0 = err_pulses;
    send_msg({4{256'h0F0F}}, 2'd0);
    repeat (9) cyc();
    bus.core_done = 1'b1;
    bus.core_hash = h;
    @(negedge clk);
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL race_err: got %b expected 0", bus.err_timeout); end
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    checks++; if (bus.dig_valid !== 1'b1) begin errors++; $display("[TB] FAIL race_dig_valid: got %b expected 1", bus.dig_valid); end
    checks++; if (bus.dig_data !== h) begin errors++; $display("[TB] FAIL race_dig_data: got %h expected %h", bus.dig_data, h); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("[TB] FAIL race_err_count: got %0d expected 0", err_pulses - e0); end
    bus.dig_ready = 1'b1;
    cyc();
    bus.dig_ready = 1'b0;
  endtask

  // Asynchronous reset in B2_WAIT, then a stray core_done must be ignored.
  task automatic test_reset_mid();
    send_msg({128{8'h3C}}, 2'd3);
    cyc();
    bus.core_done = 1'b1;
    bus.core_hash = {16{32'h7777_8888}};
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_msg_ready: got %b expected 1", bus.msg_ready); end
    checks++; if (bus.blk_start !== 1'b0) begin errors++; $display("[TB] FAIL arst_blk_start: got %b expected 0", bus.blk_start); end
    checks++; if (bus.blk_data !== 1024'd0) begin errors++; $display("[TB] FAIL arst_blk_data: got %h expected 0", bus.blk_data[63:0]); end
    checks++; if (bus.dig_data !== 512'd0) begin errors++; $display("[TB] FAIL arst_dig_data: got %h expected 0", bus.dig_data); end
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_dig_valid: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL arst_err: got %b expected 0", bus.err_timeout); end
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.core_done = 1'b1;
    bus.core_hash = {16{32'hDEAD_BEEF}};
    cyc();
    bus.core_done = 1'b0;
    bus.core_hash = '0;
    checks++; if (bus.dig_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_done_valid: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.dig_data !== 512'd0) begin errors++; $display("[TB] FAIL late_done_data: got %h expected 0", bus.dig_data); end
    checks++; if (bus.msg_ready !== 1'b1) begin errors++; $display("[TB] FAIL late_done_ready: got %b expected 1", bus.msg_ready); end
    checks++; if (bus.blk_start !== 1'b0) begin errors++; $display("[TB] FAIL late_done_start: got %b expected 0", bus.blk_start); end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_mode0();
    test_mode2();
    test_mode1_backpressure();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
